qif_spike_decoder: RTL and testbench
====================================

QIF_SPIKE_DECODER -- requirements
Module: qif_spike_decoder

Interface
REQ-001 Parameter SPIKE_TH, default 8'd200: v_mem level (unsigned) at or above which a spike is detected.
REQ-002 Parameter REARM_TH, default 8'd100: v_mem level strictly below which the detector re-arms; SPIKE_TH > REARM_TH is required.
REQ-003 Parameter ISI_W, default 16: width of the inter-spike-interval count.
REQ-004 clk  input  1  single clock for all logic, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  enable; low freezes the detector and counters.
REQ-007 v_mem  input  8  unsigned membrane-potential sample from the 8-bit QIF neuron, one per clk.
REQ-008 spike  output  1  one-cycle pulse per detected spike.
REQ-009 isi  output  ISI_W  measured inter-spike interval in clk cycles.
REQ-010 isi_valid  output  1  isi holds an unconsumed measurement.
REQ-011 isi_ready  input  1  consumer accepts isi when high with isi_valid.
REQ-012 spike_cnt  output  8  total detected spikes, wraps modulo 256.
REQ-013 overrun  output  1  sticky: a measurement was dropped.

Function
REQ-014 FSM states: IDLE (no spike seen since reset), ARMED (reference spike exists, below threshold), FIRED (above threshold, awaiting fall).
REQ-015 IDLE -> FIRED when ena=1 and v_mem >= SPIKE_TH; this is a detection with no ISI output.
REQ-016 ARMED -> FIRED when ena=1 and v_mem >= SPIKE_TH; this is a detection with ISI output.
REQ-017 FIRED -> ARMED when ena=1 and v_mem < REARM_TH; v_mem between thresholds holds FIRED (hysteresis, no re-detect).
REQ-018 spike is registered, high exactly the cycle after a detection cycle, otherwise 0.
REQ-019 isi_cnt (ISI_W bits): in a detection cycle, loads 0; otherwise, when ena=1, increments, saturating at all-ones.
REQ-020 Value reported at a detection from ARMED is min(isi_cnt+1, 2^ISI_W-1), i.e. for detections N cycles apart, isi = N.
REQ-021 The reported value loads into isi with isi_valid=1 on the cycle after detection, same cycle spike pulses.
REQ-022 isi and isi_valid are stable while isi_valid=1 and isi_ready=0; transfer occurs on a cycle with both high, after which isi_valid clears unless a new value loads.
REQ-023 New value while isi_valid=1 and isi_ready=0: the new value is dropped, isi unchanged, overrun set to 1.
REQ-024 New value on the same cycle as a transfer: the new value loads, isi_valid stays 1, no overrun.
REQ-025 spike_cnt increments on every detection (including from IDLE), wraps 255 -> 0.
REQ-026 ena=0: FSM, isi_cnt, spike_cnt hold, spike=0; the isi handshake still completes on isi_ready.
REQ-027 Saturated interval: isi_cnt at all-ones stays there; the next detection reports 2^ISI_W-1.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, isi_cnt 0, spike 0, isi 0, isi_valid 0, spike_cnt 0, overrun 0.
REQ-029 Reset mid-handshake discards the pending isi; the first detection after reset produces no ISI output.
REQ-030 overrun clears only on reset.

Structure
REQ-031 FSM state encoding and the default thresholds live in the shared neuron package alongside the QIF_8B constants.
REQ-032 One sub-module, spike_detector (threshold/hysteresis FSM plus detect pulse), is instantiated in the top; counters and handshake stay in the top.
REQ-033 The block attaches to the QIF_8B V_mem output in the tt_um top; no other dependency.

Verification
REQ-034 Sequence v_mem 0,210,50,… with the second 210 arriving 40 cycles after the first -> spike pulses twice, spike_cnt=2, single isi=40 with isi_valid.
REQ-035 v_mem 210 -> 150 -> 210 -> 50 (no dip below 100) -> exactly one spike, spike_cnt=1, no isi_valid.
REQ-036 Two detections 10 cycles apart, then a third 10 cycles later, with isi_ready=0 -> isi=10 held, overrun=1; then isi_ready=1 -> isi_valid clears after one cycle.
REQ-037 Detections 5 cycles apart with isi_ready pulsed high on each load cycle -> each isi=5, isi_valid continuous, overrun=0.
REQ-038 Detections 70000 cycles apart with ISI_W=16 -> isi=16'hFFFF.
REQ-039 rst_n low while isi_valid=1 and state FIRED -> all outputs 0 immediately (async); the next detection gives spike, no isi_valid.

Source files
------------

// File: rtl/qif_spike_decoder_pkg.sv
// Shared neuron package: QIF_8B membrane constants, spike decoder thresholds
// and the detector state encoding.
package qif_spike_decoder_pkg;

    // QIF_8B neuron membrane-potential interface
    localparam int          QIF_8B_V_W     = 8;
    localparam logic [7:0]  QIF_8B_V_REST  = 8'd0;
    localparam logic [7:0]  QIF_8B_V_PEAK  = 8'd255;

    // Default detector thresholds (SPIKE_TH must exceed REARM_TH)
    localparam logic [7:0]  SPIKE_TH_DEFAULT = 8'd200;
    localparam logic [7:0]  REARM_TH_DEFAULT = 8'd100;

    // IDLE: no reference spike yet; ARMED: reference exists, below threshold;
    // FIRED: above threshold, waiting for the membrane to fall.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } det_state_t;

endpackage

// File: rtl/qif_spike_decoder_spike_detector.sv
// Threshold/hysteresis spike detector: flags detection cycles combinationally
// and produces a registered one-cycle spike pulse.
module spike_detector
    import qif_spike_decoder_pkg::*;
#(
    parameter logic [7:0] SPIKE_TH = SPIKE_TH_DEFAULT,
    parameter logic [7:0] REARM_TH = REARM_TH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] v_mem,
    output logic       detect,
    output logic       detect_armed,
    output logic       spike
);

    det_state_t state_reg;
    det_state_t state_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and detection flags; ena low holds the state
    always_comb begin
        state_next   = state_reg;
        detect       = 1'b0;
        detect_armed = 1'b0;
        if (ena) begin
            case (state_reg)
                ST_IDLE: begin
                    if (v_mem >= SPIKE_TH) begin
                        state_next = ST_FIRED;
                        detect     = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (v_mem >= SPIKE_TH) begin
                        state_next   = ST_FIRED;
                        detect       = 1'b1;
                        detect_armed = 1'b1;
                    end
                end
                ST_FIRED: begin
                    // between thresholds stays FIRED so ringing cannot re-detect
                    if (v_mem < REARM_TH) begin
                        state_next = ST_ARMED;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Spike pulse is high the cycle after a detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike <= 1'b0;
        end else begin
            spike <= detect;
        end
    end

endmodule

// File: rtl/qif_spike_decoder.sv
// Spike decoder for the QIF_8B membrane output: detects spikes, counts them,
// and reports inter-spike intervals through a valid/ready holding register.
module qif_spike_decoder
    import qif_spike_decoder_pkg::*;
#(
    parameter logic [7:0] SPIKE_TH = SPIKE_TH_DEFAULT,
    parameter logic [7:0] REARM_TH = REARM_TH_DEFAULT,
    parameter int         ISI_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       v_mem,
    output logic             spike,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid,
    input  logic             isi_ready,
    output logic [7:0]       spike_cnt,
    output logic             overrun
);

    localparam logic [ISI_W-1:0] ISI_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_ONE = ISI_W'(1);

    logic             detect;
    logic             detect_armed;
    logic [ISI_W-1:0] isi_cnt_reg;
    logic [ISI_W-1:0] isi_report;
    logic             transfer;

    spike_detector #(
        .SPIKE_TH (SPIKE_TH),
        .REARM_TH (REARM_TH)
    ) u_spike_detector (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .v_mem        (v_mem),
        .detect       (detect),
        .detect_armed (detect_armed),
        .spike        (spike)
    );

    // The counter sits at N-1 on a detection N cycles after the previous one,
    // so the reported interval is the count plus one, saturated.
    assign isi_report = (isi_cnt_reg == ISI_MAX) ? ISI_MAX : (isi_cnt_reg + ISI_ONE);
    assign transfer   = isi_valid && isi_ready;

    // Interval counter: restart on detection, saturating count while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_cnt_reg <= '0;
        end else if (detect) begin
            isi_cnt_reg <= '0;
        end else if (ena && (isi_cnt_reg != ISI_MAX)) begin
            isi_cnt_reg <= isi_cnt_reg + ISI_ONE;
        end
    end

    // Total spike count, wraps modulo 256
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_cnt <= 8'd0;
        end else if (detect) begin
            spike_cnt <= spike_cnt + 8'd1;
        end
    end

    // Holding register: a new interval loads only if the slot is empty or
    // being drained this cycle; otherwise it is dropped and overrun sticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi       <= '0;
            isi_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (detect_armed) begin
                if (!isi_valid || isi_ready) begin
                    isi       <= isi_report;
                    isi_valid <= 1'b1;
                end else begin
                    overrun   <= 1'b1;
                end
            end else if (transfer) begin
                isi_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qif_spike_decoder.sv
// Self-checking bench for qif_spike_decoder: a directed vector table followed
// by hand-written multi-cycle sequences.
module tb_qif_spike_decoder;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [7:0]  v_mem;
    logic        spike;
    logic [15:0] isi;
    logic        isi_valid;
    logic        isi_ready;
    logic [7:0]  spike_cnt;
    logic        overrun;

    int tests;
    int fails;
    int spike_pulses;
    int valid_low_cnt;

    qif_spike_decoder #(
        .SPIKE_TH (8'd200),
        .REARM_TH (8'd100),
        .ISI_W    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .v_mem     (v_mem),
        .spike     (spike),
        .isi       (isi),
        .isi_valid (isi_valid),
        .isi_ready (isi_ready),
        .spike_cnt (spike_cnt),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ena;
        logic [7:0]  v;
        logic        rdy;
        logic        e_spike;
        logic        e_valid;
        logic [15:0] e_isi;
        logic [7:0]  e_cnt;
        logic        e_ovr;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge; outputs are settled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
        if (spike) spike_pulses++;
        if (!isi_valid) valid_low_cnt++;
    endtask

    task automatic do_reset();
        ena       = 1'b1;
        v_mem     = 8'd0;
        isi_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        spike_pulses  = 0;
        valid_low_cnt = 0;
    endtask

    task automatic fire();
        v_mem = 8'd210;
        tick();
    endtask

    // Next detection n cycles after the previous one
    task automatic gap(input int n, input logic rdy_on_fire);
        v_mem     = 8'd50;
        isi_ready = 1'b0;
        for (int k = 0; k < n - 1; k++) tick();
        v_mem     = 8'd210;
        isi_ready = rdy_on_fire;
        tick();
        isi_ready = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        ena = 1'b1;
        v_mem = 8'd0;
        isi_ready = 1'b0;

        // ena, v_mem, ready -> spike, isi_valid, isi, spike_cnt, overrun
        vecs[0]  = '{1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0};
        vecs[1]  = '{1'b1, 8'd210, 1'b0, 1'b1, 1'b0, 16'd0, 8'd1, 1'b0};
        vecs[2]  = '{1'b1, 8'd150, 1'b0, 1'b0, 1'b0, 16'd0, 8'd1, 1'b0};
        vecs[3]  = '{1'b1, 8'd210, 1'b0, 1'b0, 1'b0, 16'd0, 8'd1, 1'b0};
        vecs[4]  = '{1'b1, 8'd50,  1'b0, 1'b0, 1'b0, 16'd0, 8'd1, 1'b0};
        vecs[5]  = '{1'b1, 8'd60,  1'b0, 1'b0, 1'b0, 16'd0, 8'd1, 1'b0};
        vecs[6]  = '{1'b1, 8'd200, 1'b0, 1'b1, 1'b1, 16'd5, 8'd2, 1'b0};
        vecs[7]  = '{1'b0, 8'd50,  1'b0, 1'b0, 1'b1, 16'd5, 8'd2, 1'b0};
        vecs[8]  = '{1'b0, 8'd210, 1'b0, 1'b0, 1'b1, 16'd5, 8'd2, 1'b0};
        vecs[9]  = '{1'b1, 8'd100, 1'b0, 1'b0, 1'b1, 16'd5, 8'd2, 1'b0};
        vecs[10] = '{1'b1, 8'd99,  1'b0, 1'b0, 1'b1, 16'd5, 8'd2, 1'b0};
        vecs[11] = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 16'd5, 8'd2, 1'b0};
        vecs[12] = '{1'b1, 8'd255, 1'b0, 1'b1, 1'b1, 16'd3, 8'd3, 1'b0};
        vecs[13] = '{1'b1, 8'd10,  1'b0, 1'b0, 1'b1, 16'd3, 8'd3, 1'b0};
        vecs[14] = '{1'b1, 8'd200, 1'b0, 1'b1, 1'b1, 16'd3, 8'd4, 1'b1};
        vecs[15] = '{1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 16'd3, 8'd4, 1'b1};

        // Reset state
        do_reset();
        check("reset_spike", 32'(spike), 32'd0);
        check("reset_isi", 32'(isi), 32'd0);
        check("reset_valid", 32'(isi_valid), 32'd0);
        check("reset_cnt", 32'(spike_cnt), 32'd0);
        check("reset_ovr", 32'(overrun), 32'd0);

        // Vector table
        for (int i = 0; i < 16; i++) begin
            ena       = vecs[i].ena;
            v_mem     = vecs[i].v;
            isi_ready = vecs[i].rdy;
            tick();
            $display("[TB] vec %0d ena=%0d v=%0d rdy=%0d -> spike=%0d valid=%0d isi=%0d cnt=%0d ovr=%0d",
                     i, ena, v_mem, isi_ready, spike, isi_valid, isi, spike_cnt, overrun);
            check($sformatf("vec%0d_spike", i), 32'(spike), 32'(vecs[i].e_spike));
            check($sformatf("vec%0d_valid", i), 32'(isi_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_isi", i), 32'(isi), 32'(vecs[i].e_isi));
            check($sformatf("vec%0d_cnt", i), 32'(spike_cnt), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].e_ovr));
        end

        // Two spikes 40 cycles apart
        do_reset();
        v_mem = 8'd0;
        tick();
        fire();
        gap(40, 1'b0);
        $display("[TB] isi40: spikes=%0d cnt=%0d isi=%0d valid=%0d", spike_pulses, spike_cnt, isi, isi_valid);
        check("isi40_pulses", 32'(spike_pulses), 32'd2);
        check("isi40_cnt", 32'(spike_cnt), 32'd2);
        check("isi40_isi", 32'(isi), 32'd40);
        check("isi40_valid", 32'(isi_valid), 32'd1);

        // Hysteresis: no dip below REARM_TH gives a single spike
        do_reset();
        v_mem = 8'd210; tick();
        v_mem = 8'd150; tick();
        v_mem = 8'd210; tick();
        v_mem = 8'd50;  tick();
        tick();
        $display("[TB] hyst: spikes=%0d cnt=%0d valid=%0d", spike_pulses, spike_cnt, isi_valid);
        check("hyst_pulses", 32'(spike_pulses), 32'd1);
        check("hyst_cnt", 32'(spike_cnt), 32'd1);
        check("hyst_valid", 32'(isi_valid), 32'd0);

        // Overrun: third detection while the first interval is unconsumed
        do_reset();
        fire();
        gap(10, 1'b0);
        check("ovr_first_isi", 32'(isi), 32'd10);
        check("ovr_first_ovr", 32'(overrun), 32'd0);
        gap(10, 1'b0);
        $display("[TB] overrun: isi=%0d valid=%0d ovr=%0d", isi, isi_valid, overrun);
        check("ovr_isi_held", 32'(isi), 32'd10);
        check("ovr_valid", 32'(isi_valid), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        v_mem = 8'd50;
        isi_ready = 1'b1;
        tick();
        isi_ready = 1'b0;
        $display("[TB] overrun drain: valid=%0d ovr=%0d", isi_valid, overrun);
        check("ovr_drain_valid", 32'(isi_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Back-to-back transfers: ready on each new-value cycle keeps valid high
        do_reset();
        fire();
        gap(5, 1'b1);
        valid_low_cnt = 0;
        for (int r = 0; r < 3; r++) begin
            gap(5, 1'b1);
            $display("[TB] b2b %0d: isi=%0d valid=%0d ovr=%0d", r, isi, isi_valid, overrun);
            check($sformatf("b2b%0d_isi", r), 32'(isi), 32'd5);
            check($sformatf("b2b%0d_valid", r), 32'(isi_valid), 32'd1);
        end
        check("b2b_valid_continuous", 32'(valid_low_cnt), 32'd0);
        check("b2b_ovr", 32'(overrun), 32'd0);

        // Saturated interval
        do_reset();
        fire();
        gap(70000, 1'b0);
        $display("[TB] saturate: isi=%0h valid=%0d", isi, isi_valid);
        check("sat_isi", 32'(isi), 32'hFFFF);
        check("sat_valid", 32'(isi_valid), 32'd1);

        // Asynchronous reset mid-handshake while FIRED
        do_reset();
        fire();
        gap(4, 1'b0);
        check("arst_pre_valid", 32'(isi_valid), 32'd1);
        check("arst_pre_spike", 32'(spike), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset: spike=%0d isi=%0d valid=%0d cnt=%0d ovr=%0d",
                 spike, isi, isi_valid, spike_cnt, overrun);
        check("arst_spike", 32'(spike), 32'd0);
        check("arst_isi", 32'(isi), 32'd0);
        check("arst_valid", 32'(isi_valid), 32'd0);
        check("arst_cnt", 32'(spike_cnt), 32'd0);
        check("arst_ovr", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v_mem = 8'd210;
        tick();
        $display("[TB] post reset detect: spike=%0d valid=%0d cnt=%0d", spike, isi_valid, spike_cnt);
        check("arst_post_spike", 32'(spike), 32'd1);
        check("arst_post_valid", 32'(isi_valid), 32'd0);
        check("arst_post_cnt", 32'(spike_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
